// File: rtl/pipe_ctrl.sv
// Pipeline controller for the KANADE32 core: tracks per-stage valid/destination state,
// interlocks decode on read-after-write hazards, flushes on taken branches, gates retirement.
module pipe_ctrl #(
  parameter int NSTAGE   = 5,
  parameter int BR_STAGE = 2,
  parameter int RADDR_W  = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               imem_ready,
  input  logic [RADDR_W-1:0] dec_rs0,
  input  logic [RADDR_W-1:0] dec_rs1,
  input  logic               dec_rs0_use,
  input  logic               dec_rs1_use,
  input  logic [RADDR_W-1:0] dec_rd,
  input  logic               dec_rd_write,
  input  logic               br_taken,
  output logic               pc_wren,
  output logic [NSTAGE-2:0]  stage_wren,
  output logic [NSTAGE-2:0]  stage_valid,
  output logic               stall,
  output logic               flush,
  output logic               rf_wren,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [31:0]        retire_cnt
);

  localparam int LAST = NSTAGE - 2;

  logic [LAST:0]        v_q;
  logic [RADDR_W-1:0]   rd_q [1:LAST];
  logic [LAST:1]        rdw_q;
  logic                 hazard;
  logic [LAST:0]        v_nxt;

  // A bubble or a write to x0 can never be a producer.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    hazard = 1'b0;
    for (int i = 1; i <= LAST; i++) begin
      if (v_q[i] && rdw_q[i] && (rd_q[i] != '0) &&
          ((dec_rs0_use && (dec_rs0 == rd_q[i])) ||
           (dec_rs1_use && (dec_rs1 == rd_q[i]))))
        hazard = 1'b1;
    end
  end

  assign flush    = reset_n & run & br_taken & v_q[BR_STAGE-1];
  assign stall    = reset_n & run & v_q[0] & hazard;
  assign pc_wren  = reset_n & run & (flush | (~stall & imem_ready));
  assign rf_wren  = reset_n & run & v_q[LAST] & rdw_q[LAST] & (rd_q[LAST] != '0);
  assign rf_waddr = rd_q[LAST];
  assign stage_valid = v_q;

  // Only a stall without a competing flush holds FD; every other running cycle loads all stages.
  always_comb begin
    stage_wren = '0;
    if (reset_n && run) begin
      stage_wren = '1;
      if (stall && !flush)
        stage_wren[0] = 1'b0;
    end
  end

  always_comb begin
    v_nxt = v_q;
    if (run) begin
      for (int i = 1; i <= LAST; i++)
        v_nxt[i] = v_q[i-1];
      if (flush) begin
        for (int i = 0; i < BR_STAGE; i++)
          v_nxt[i] = 1'b0;
      end else if (stall) begin
        v_nxt[0] = v_q[0];
        v_nxt[1] = 1'b0;
      end else begin
        v_nxt[0] = imem_ready;
      end
    end
  end

  // The destination table is small, so it is reset along with the valids.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q        <= '0;
      rdw_q      <= '0;
      retire_cnt <= '0;
      for (int i = 1; i <= LAST; i++)
        rd_q[i] <= '0;
    end else if (run) begin
      // NOTE: non-blocking assignments so every stage shifts from pre-edge values.
      v_q      <= v_nxt;
      rd_q[1]  <= dec_rd;
      rdw_q[1] <= dec_rd_write;
      for (int i = 2; i <= LAST; i++) begin
        rd_q[i]  <= rd_q[i-1];
        rdw_q[i] <= rdw_q[i-1];
      end
      if (v_q[LAST])
        retire_cnt <= retire_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (NSTAGE=5, BR_STAGE=2): cycle-by-cycle expectations plus a
// scoreboard of register-file write addresses checked by an independent monitor.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       imem_ready;
  logic [4:0] dec_rs0, dec_rs1, dec_rd;
  logic       dec_rs0_use, dec_rs1_use, dec_rd_write;
  logic       br_taken;
  logic       pc_wren;
  logic [3:0] stage_wren;
  logic [3:0] stage_valid;
  logic       stall, flush, rf_wren;
  logic [4:0] rf_waddr;
  logic [31:0] retire_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] exp_q [$];

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGE(5), .BR_STAGE(2), .RADDR_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .imem_ready(imem_ready),
    .dec_rs0(dec_rs0), .dec_rs1(dec_rs1), .dec_rs0_use(dec_rs0_use),
    .dec_rs1_use(dec_rs1_use), .dec_rd(dec_rd), .dec_rd_write(dec_rd_write),
    .br_taken(br_taken), .pc_wren(pc_wren), .stage_wren(stage_wren),
    .stage_valid(stage_valid), .stall(stall), .flush(flush), .rf_wren(rf_wren),
    .rf_waddr(rf_waddr), .retire_cnt(retire_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic clear_dec();
    dec_rs0 = 5'd0; dec_rs1 = 5'd0; dec_rd = 5'd0;
    dec_rs0_use = 1'b0; dec_rs1_use = 1'b0; dec_rd_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Every retiring write must match the oldest queued destination.
  always @(negedge clk) begin
    if (rf_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rf_write_unexpected: got waddr %0d expected no write at %0t", rf_waddr, $time);
      end else begin
        check("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [3:0] fill_sv [4];
    fill_sv[0] = 4'b0001; fill_sv[1] = 4'b0011; fill_sv[2] = 4'b0111; fill_sv[3] = 4'b1111;

    reset_n = 1'b0; run = 1'b0; imem_ready = 1'b0; br_taken = 1'b0; clear_dec();
    #2;
    check("rst_valid", {28'd0, stage_valid}, 32'h0);
    check("rst_cnt", retire_cnt, 32'h0);
    run = 1'b1; imem_ready = 1'b1; br_taken = 1'b1;
    #1;
    check("rst_pc_wren", {31'd0, pc_wren}, 32'h0);
    check("rst_stage_wren", {28'd0, stage_wren}, 32'h0);
    check("rst_flush", {31'd0, flush}, 32'h0);
    br_taken = 1'b0;
    step();
    reset_n = 1'b1;

    // S0: empty pipe, normal fetch
    sample();
    check("s0_pc_wren", {31'd0, pc_wren}, 32'h1);
    check("s0_stage_wren", {28'd0, stage_wren}, 32'hF);
    step();

    // S1..S4: fill
    for (int i = 0; i < 4; i++) begin
      sample();
      check("fill_valid", {28'd0, stage_valid}, {28'd0, fill_sv[i]});
      check("fill_stall", {31'd0, stall}, 32'h0);
      check("fill_cnt", retire_cnt, 32'h0);
      step();
    end

    // S5: producer writes x3
    dec_rd = 5'd3; dec_rd_write = 1'b1; exp_q.push_back(5'd3);
    sample();
    check("s5_cnt", retire_cnt, 32'd1);
    check("s5_stall", {31'd0, stall}, 32'h0);
    step();
    // S6..S8: consumer reads x3 -> three interlock cycles
    clear_dec(); dec_rs0 = 5'd3; dec_rs0_use = 1'b1;
    sample();
    check("haz_stall1", {31'd0, stall}, 32'h1);
    check("haz_pc_wren", {31'd0, pc_wren}, 32'h0);
    check("haz_stage_wren", {28'd0, stage_wren}, 32'hE);
    check("haz_valid1", {28'd0, stage_valid}, 32'hF);
    step();
    sample();
    check("haz_stall2", {31'd0, stall}, 32'h1);
    check("haz_valid2", {28'd0, stage_valid}, 32'hD);
    step();
    sample();
    check("haz_stall3", {31'd0, stall}, 32'h1);
    check("haz_valid3", {28'd0, stage_valid}, 32'h9);
    check("haz_rf_wren", {31'd0, rf_wren}, 32'h1);
    step();
    // S9: producer gone
    sample();
    check("haz_release", {31'd0, stall}, 32'h0);
    check("haz_valid4", {28'd0, stage_valid}, 32'h1);
    check("s9_cnt", retire_cnt, 32'd5);
    step();

    // S10: producer of x0; S11: consumer of x0
    clear_dec(); dec_rd = 5'd0; dec_rd_write = 1'b1;
    sample(); step();
    clear_dec(); dec_rs1 = 5'd0; dec_rs1_use = 1'b1;
    sample();
    check("x0_no_stall", {31'd0, stall}, 32'h0);
    step();
    clear_dec();
    sample(); step();

    // S13: x0 producer retires without a write; taken branch in r[1]
    br_taken = 1'b1;
    sample();
    check("x0_rf_wren", {31'd0, rf_wren}, 32'h0);
    check("s13_cnt", retire_cnt, 32'd6);
    check("flush_on", {31'd0, flush}, 32'h1);
    check("flush_pc_wren", {31'd0, pc_wren}, 32'h1);
    check("flush_stage_wren", {28'd0, stage_wren}, 32'hF);
    step();
    // S14: r[1] now a bubble, so br_taken is disqualified
    sample();
    check("flush_valid", {28'd0, stage_valid}, 32'hC);
    check("flush_bubble_off", {31'd0, flush}, 32'h0);
    check("s14_cnt", retire_cnt, 32'd7);
    br_taken = 1'b0;
    step();

    // S15: branch instruction that also writes x7
    dec_rd = 5'd7; dec_rd_write = 1'b1; exp_q.push_back(5'd7);
    sample();
    check("s15_valid", {28'd0, stage_valid}, 32'h9);
    step();
    // S16: hazard on x7 and taken branch at once: flush wins
    clear_dec(); dec_rs0 = 5'd7; dec_rs0_use = 1'b1; br_taken = 1'b1;
    sample();
    check("fh_flush", {31'd0, flush}, 32'h1);
    check("fh_pc_wren", {31'd0, pc_wren}, 32'h1);
    check("fh_stage_wren", {28'd0, stage_wren}, 32'hF);
    step();
    clear_dec(); br_taken = 1'b0;
    sample();
    check("fh_valid", {28'd0, stage_valid}, 32'h4);
    check("fh_stall", {31'd0, stall}, 32'h0);
    check("s17_cnt", retire_cnt, 32'd9);
    step();
    sample();
    check("s18_valid", {28'd0, stage_valid}, 32'h9);
    check("s18_rf_wren", {31'd0, rf_wren}, 32'h1);
    step();

    // S19, S20: fetch not ready
    imem_ready = 1'b0;
    sample();
    check("imem_pc_wren1", {31'd0, pc_wren}, 32'h0);
    check("s19_cnt", retire_cnt, 32'd10);
    step();
    sample();
    check("imem_pc_wren2", {31'd0, pc_wren}, 32'h0);
    check("imem_valid1", {28'd0, stage_valid}, 32'h6);
    step();
    imem_ready = 1'b1;
    sample();
    check("imem_valid2", {28'd0, stage_valid}, 32'hC);
    step();
    sample();
    check("imem_valid3", {28'd0, stage_valid}, 32'h9);
    check("s22_cnt", retire_cnt, 32'd11);
    step();
    sample();
    check("s23_cnt", retire_cnt, 32'd12);
    step();
    step();

    // S25..S27: frozen pipeline ignores all inputs
    run = 1'b0; br_taken = 1'b1; imem_ready = 1'b0;
    sample();
    check("frz_pc_wren", {31'd0, pc_wren}, 32'h0);
    check("frz_stage_wren", {28'd0, stage_wren}, 32'h0);
    check("frz_flush", {31'd0, flush}, 32'h0);
    check("frz_stall", {31'd0, stall}, 32'h0);
    check("frz_valid0", {28'd0, stage_valid}, 32'hF);
    step();
    sample(); step();
    sample();
    check("frz_valid", {28'd0, stage_valid}, 32'hF);
    check("frz_cnt", retire_cnt, 32'd12);

    // Counter wrap: preload the counter while frozen, then retire one instruction
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    run = 1'b1; br_taken = 1'b0; imem_ready = 1'b1;
    step();
    sample();
    check("wrap_cnt", retire_cnt, 32'h0);
    step();
    sample();
    check("wrap_cnt_next", retire_cnt, 32'd1);

    // Asynchronous reset mid-cycle
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", {28'd0, stage_valid}, 32'h0);
    check("arst_cnt", retire_cnt, 32'h0);
    check("arst_pc_wren", {31'd0, pc_wren}, 32'h0);
    step();
    reset_n = 1'b1;
    sample();
    check("post_rst_pc_wren", {31'd0, pc_wren}, 32'h1);
    step();
    sample();
    check("post_rst_valid", {28'd0, stage_valid}, 32'h1);

    check("sb_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
